octal_seg_decoder: RTL
======================

// Module: octal_seg_decoder
// PURPOSE
//  Inverse of the octal 7-segment display encoder. Accepts a digit stream of
//  7-segment patterns, low digit then high digit, and reconstructs the 16-bit
//  one-hot code (bit n = octal value n, 0..17 octal) plus its 4-bit value.
//  Sits on the loopback/check path that reads back display segment drive.
// PARAMETERS
//  TIMEOUT  255  max cycles in WAIT_HI without a high digit before abort (>=1)
//  TW       8    width of timeout counter; must hold TIMEOUT
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  seg_valid  in   1   seg_data/seg_hi valid
//  seg_ready  out  1   decoder can accept a digit
//  seg_data   in   7   segment pattern, bit6..0 = a b c d e f g
//  seg_hi     in   1   0 = low (ones) digit, 1 = high (eights) digit
//  out_valid  out  1   decoded result valid
//  out_ready  in   1   consumer accepts result
//  onehot     out  16  reconstructed one-hot code
//  value      out  4   binary value 0..15
//  blank      out  1   both digits blank (no code)
//  bad_seg    out  1   illegal pattern or combination
//  seq_err    out  1   1-cycle pulse: digit out of order
//  timeout    out  1   1-cycle pulse: high digit never arrived
// BEHAVIOUR
//  Reset (async, rst_n=0): state WAIT_LO, seg_ready=1; out_valid, onehot, value,
//   blank, bad_seg, seq_err, timeout, stored low digit, counter all 0.
//  Digit transfer = seg_valid & seg_ready on a rising edge.
//  Low patterns: 1111110=0 0110000=1 1101101=2 1111001=3 0110011=4
//   1011011=5 1011111=6 1110000=7 0000000=blank; others illegal.
//  High patterns: 0000000 -> +0, 0110000 -> +8; others illegal.
//  FSM:
//   WAIT_LO: lo transfer -> store pattern, clear counter, -> WAIT_HI.
//            hi transfer -> discard, seq_err pulse, stay.
//   WAIT_HI: hi transfer -> decode, register outputs, -> OUT.
//            lo transfer -> overwrite stored lo, clear counter, seq_err, stay.
//            else counter++; counter==TIMEOUT -> timeout pulse, -> WAIT_LO.
//            hi transfer on same cycle as counter==TIMEOUT: transfer wins.
//   OUT:     seg_ready=0; out_valid=1; outputs held stable until out_ready;
//            on out_valid&out_ready -> WAIT_LO, out_valid=0 next cycle.
//  seg_ready = 1 in WAIT_LO/WAIT_HI, 0 in OUT (registered from state).
//  Latency: out_valid rises the cycle after the hi-digit transfer edge.
//  Decode: value = lo + hi*8; onehot = 1<<value; blank=0, bad_seg=0.
//   lo blank & hi blank -> onehot=0, value=0, blank=1, bad_seg=0.
//   Any illegal pattern, or lo blank with hi=0110000 -> onehot=0, value=0,
//   blank=0, bad_seg=1. Flags are sticky only while out_valid.
//  seq_err/timeout: pulse high exactly one cycle after the triggering edge.
//  Reset mid-operation: everything returns to reset values, partial digit lost.
// TESTING
//  1 lo=1110000, hi=0000000 -> out_valid, onehot=16'h0080, value=7, flags 0.
//  2 lo=1011011, hi=0110000, out_ready held 0 for 5 cycles -> outputs stable,
//    seg_ready=0; then out_ready=1 -> onehot=16'h2000, value=13, back to WAIT_LO.
//  3 lo=0000000, hi=0000000 -> blank=1, onehot=0; lo=0000000, hi=0110000
//    -> bad_seg=1; lo=1111111 -> bad_seg=1 after hi digit.
//  4 hi digit first -> seq_err pulse, discarded; lo=0110000 then lo=1101101
//    then hi=0000000 -> one seq_err, value=2.
//  5 TIMEOUT=4: lo then idle -> timeout pulse after 4 idle cycles, state WAIT_LO;
//    hi on the 4th idle cycle -> accepted, no timeout pulse.
//  6 rst_n low while in WAIT_HI and while in OUT -> all outputs 0, seg_ready=1.

Source files
------------

// File: rtl/octal_seg_decoder.sv
// Rebuilds a 16-bit one-hot code and its 4-bit value from a pair of 7-segment digits
// (low ones digit first, then high eights digit). Used to read back the display segment drive.
module octal_seg_decoder #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seg_valid,
    output logic        seg_ready,
    input  logic [6:0]  seg_data,
    input  logic        seg_hi,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] onehot,
    output logic [3:0]  value,
    output logic        blank,
    output logic        bad_seg,
    output logic        seq_err,
    output logic        timeout
);

    typedef enum logic [1:0] {
        WAIT_LO = 2'd0,
        WAIT_HI = 2'd1,
        OUT     = 2'd2
    } state_t;

    localparam logic [TW:0] TIMEOUT_W = (TW+1)'(TIMEOUT);

    state_t        state, state_nxt;
    logic [6:0]    lo_q, lo_nxt;
    logic [TW-1:0] cnt, cnt_nxt;
    logic [TW:0]   cnt_inc;
    logic [15:0]   onehot_nxt;
    logic [3:0]    value_nxt;
    logic          blank_nxt, bad_nxt, seq_err_nxt, timeout_nxt;
    logic          xfer;

    logic          lo_ok, lo_blank;
    logic [2:0]    lo_val;
    logic          hi_ok, hi_one;

    assign seg_ready = (state != OUT);
    assign out_valid = (state == OUT);
    assign xfer      = seg_valid & seg_ready;
    assign cnt_inc   = {1'b0, cnt} + (TW+1)'(1);

    // Segment order is a b c d e f g from bit 6 down to bit 0
    always_comb begin
        lo_ok    = 1'b1;
        lo_blank = 1'b0;
        lo_val   = 3'd0;
        case (lo_q)
            7'b1111110: lo_val = 3'd0;
            7'b0110000: lo_val = 3'd1;
            7'b1101101: lo_val = 3'd2;
            7'b1111001: lo_val = 3'd3;
            7'b0110011: lo_val = 3'd4;
            7'b1011011: lo_val = 3'd5;
            7'b1011111: lo_val = 3'd6;
            7'b1110000: lo_val = 3'd7;
            7'b0000000: lo_blank = 1'b1;
            default:    lo_ok = 1'b0;
        endcase
    end

    assign hi_one = (seg_data == 7'b0110000);
    assign hi_ok  = hi_one || (seg_data == 7'b0000000);

    always_comb begin
        state_nxt   = state;
        lo_nxt      = lo_q;
        cnt_nxt     = cnt;
        onehot_nxt  = onehot;
        value_nxt   = value;
        blank_nxt   = blank;
        bad_nxt     = bad_seg;
        seq_err_nxt = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            WAIT_LO: begin
                if (xfer && !seg_hi) begin
                    lo_nxt    = seg_data;
                    cnt_nxt   = '0;
                    state_nxt = WAIT_HI;
                end else if (xfer) begin
                    seq_err_nxt = 1'b1;
                end
            end
            WAIT_HI: begin
                if (xfer && seg_hi) begin
                    state_nxt = OUT;
                    if (!lo_ok || !hi_ok || (lo_blank && hi_one)) begin
                        onehot_nxt = '0;
                        value_nxt  = '0;
                        blank_nxt  = 1'b0;
                        bad_nxt    = 1'b1;
                    end else if (lo_blank) begin
                        onehot_nxt = '0;
                        value_nxt  = '0;
                        blank_nxt  = 1'b1;
                        bad_nxt    = 1'b0;
                    end else begin
                        value_nxt  = {hi_one, lo_val};
                        onehot_nxt = 16'd1 << {hi_one, lo_val};
                        blank_nxt  = 1'b0;
                        bad_nxt    = 1'b0;
                    end
                end else if (xfer) begin
                    lo_nxt      = seg_data;
                    cnt_nxt     = '0;
                    seq_err_nxt = 1'b1;
                end else if (cnt_inc == TIMEOUT_W) begin
                    // A high digit landing on this same edge takes the branch above instead
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b1;
                    state_nxt   = WAIT_LO;
                end else begin
                    cnt_nxt = cnt_inc[TW-1:0];
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_nxt  = WAIT_LO;
                    onehot_nxt = '0;
                    value_nxt  = '0;
                    blank_nxt  = 1'b0;
                    bad_nxt    = 1'b0;
                end
            end
            default: state_nxt = WAIT_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAIT_LO;
            lo_q    <= '0;
            cnt     <= '0;
            onehot  <= '0;
            value   <= '0;
            blank   <= 1'b0;
            bad_seg <= 1'b0;
            seq_err <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            lo_q    <= lo_nxt;
            cnt     <= cnt_nxt;
            onehot  <= onehot_nxt;
            value   <= value_nxt;
            blank   <= blank_nxt;
            bad_seg <= bad_nxt;
            seq_err <= seq_err_nxt;
            timeout <= timeout_nxt;
        end
    end

endmodule
